// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: prefetches one scanline into a line buffer and lets a CPU
// share the framebuffer port. Optional CPU slot during fetch: VGA_FB_CPU_SLOT_EN.
module vga_fb_arbiter #(
  parameter int unsigned WORDS_PER_LINE = 80,
  parameter int unsigned LINES          = 480,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic              frame_start,
  input  logic [15:0]       line_y,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [15:0]       lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              fetch_done,
  output logic              overrun
);

  localparam int unsigned LB_W = 16;
  localparam logic [LB_W-1:0] LAST_WORD = LB_W'(WORDS_PER_LINE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LB_W-1:0]   word_q, word_d;
  logic              overrun_q, overrun_d;
  logic              lb_we_q, lb_last_q, fetch_done_q, cpu_rvalid_q;
  logic [LB_W-1:0]   lb_addr_q;

  logic              cpu_grant, disp_grant, last_issue, cpu_slot, line_ok;
  logic [ADDR_W-1:0] line_base;

  assign line_ok   = 32'(line_y) < LINES;
  assign line_base = ADDR_W'(line_y) * ADDR_W'(WORDS_PER_LINE);

`ifdef VGA_FB_CPU_SLOT_EN
  // Slot counter runs only while fetching; every fourth fetch cycle belongs to the CPU.
  logic [1:0] slot_q, slot_d;

  assign slot_d   = (state_q == FETCH) ? slot_q + 2'd1 : 2'd0;
  assign cpu_slot = (slot_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= 2'd0;
    else        slot_q <= slot_d;
  end
`else
  assign cpu_slot = 1'b0;
`endif

  // Next-state, grant and overrun logic.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    word_d     = word_q;
    overrun_d  = overrun_q;
    cpu_grant  = 1'b0;
    disp_grant = 1'b0;
    last_issue = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_grant = cpu_valid & rst_n;
        if (line_start && line_ok) begin
          state_d = FETCH;
          base_d  = line_base;
          word_d  = '0;
        end
      end
      FETCH: begin
        cpu_grant  = cpu_slot & cpu_valid & rst_n;
        disp_grant = ~cpu_grant;
        if (disp_grant) begin
          word_d = word_q + LB_W'(1);
          if (word_q == LAST_WORD) begin
            last_issue = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_start)                     overrun_d = 1'b0;
    if (line_start && state_q == FETCH)  overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      word_q       <= '0;
      overrun_q    <= 1'b0;
      lb_we_q      <= 1'b0;
      lb_addr_q    <= '0;
      lb_last_q    <= 1'b0;
      fetch_done_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      word_q       <= word_d;
      overrun_q    <= overrun_d;
      lb_we_q      <= disp_grant;
      lb_addr_q    <= disp_grant ? word_q : lb_addr_q;
      lb_last_q    <= last_issue;
      fetch_done_q <= lb_last_q;
      cpu_rvalid_q <= cpu_grant & ~cpu_we;
    end
  end

  // Memory port is driven in the grant cycle; read data is steered one cycle later.
  assign cpu_ready  = cpu_grant;
  assign mem_en     = cpu_grant | disp_grant;
  assign mem_we     = cpu_grant & cpu_we;
  assign mem_addr   = disp_grant ? base_q + ADDR_W'(word_q) :
                      (cpu_grant ? cpu_addr : '0);
  assign mem_wdata  = (cpu_grant && cpu_we) ? cpu_wdata : '0;
  assign lb_we      = lb_we_q;
  assign lb_addr    = lb_addr_q;
  assign lb_wdata   = lb_we_q ? mem_rdata : '0;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;
  assign fetch_done = fetch_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scanline/CPU/overrun/reset scenarios plus random
// traffic, all checked against a transaction-level reference model.
module tb_vga_fb_arbiter;

  localparam int unsigned WPL   = 80;
  localparam int unsigned LINES = 480;
`ifdef VGA_FB_CPU_SLOT_EN
  localparam bit SLOT_EN = 1'b1;
`else
  localparam bit SLOT_EN = 1'b0;
`endif

  logic        clk, rst_n, line_start, frame_start;
  logic [15:0] line_y;
  logic        cpu_valid, cpu_ready, cpu_we, cpu_rvalid;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        lb_we;
  logic [15:0] lb_addr;
  logic [31:0] lb_wdata;
  logic        fetch_done, overrun;

  vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .frame_start(frame_start),
    .line_y(line_y), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_wdata(lb_wdata), .fetch_done(fetch_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Framebuffer: unwritten words read back as their own address.
  logic [31:0] wmem [logic [15:0]];

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    return wmem.exists(a) ? wmem[a] : 32'(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) wmem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem_rd(mem_addr);
    end
  end

  // Reference model: a line fetch is "WPL words still owed starting at base".
  int unsigned m_left = 0, m_idx = 0, m_fcyc = 0, m_base = 0;
  bit          m_ovr = 1'b0, p_lb = 1'b0, p_last = 1'b0, p_done = 1'b0, p_rv = 1'b0;
  logic [15:0] p_idx = '0;
  logic [31:0] p_lbd = '0, p_rd = '0;
  bit          e_slot, e_cpu, e_disp, acc_q = 1'b0;
  logic [15:0] e_addr;
  int unsigned disp_cnt = 0;
  logic [15:0] last_disp_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_flags", 32'({cpu_ready, cpu_rvalid, mem_en, mem_we, lb_we, fetch_done, overrun}), 32'h0);
      check("rst_addr", {mem_addr, lb_addr}, 32'h0);
      check("rst_data", mem_wdata | lb_wdata | cpu_rdata, 32'h0);
      m_left = 0; m_ovr = 1'b0; p_lb = 1'b0; p_last = 1'b0; p_done = 1'b0; p_rv = 1'b0;
      acc_q = 1'b0;
    end else begin
      e_slot = SLOT_EN && (m_left > 0) && (m_fcyc % 4 == 3) && cpu_valid;
      e_cpu  = cpu_valid && (m_left == 0 || e_slot);
      e_disp = (m_left > 0) && !e_slot;
      e_addr = e_disp ? 16'(m_base + m_idx) : (e_cpu ? cpu_addr : 16'h0);
      check("cpu_ready", 32'(cpu_ready), 32'(e_cpu));
      check("mem_en", 32'(mem_en), 32'(e_cpu | e_disp));
      check("mem_we", 32'(mem_we), 32'(e_cpu & cpu_we));
      check("mem_addr", 32'(mem_addr), 32'(e_addr));
      check("mem_wdata", mem_wdata, (e_cpu && cpu_we) ? cpu_wdata : 32'h0);
      check("lb_we", 32'(lb_we), 32'(p_lb));
      if (p_lb) begin
        check("lb_addr", 32'(lb_addr), 32'(p_idx));
        check("lb_wdata", lb_wdata, p_lbd);
      end
      check("fetch_done", 32'(fetch_done), 32'(p_done));
      check("cpu_rvalid", 32'(cpu_rvalid), 32'(p_rv));
      if (p_rv) check("cpu_rdata", cpu_rdata, p_rd);
      check("overrun", 32'(overrun), 32'(m_ovr));
      if (mem_en && !cpu_ready) begin
        disp_cnt++;
        last_disp_addr = mem_addr;
      end
      acc_q  = cpu_valid && cpu_ready;
      p_done = p_lb && p_last;
      p_last = e_disp && (m_idx == WPL - 1);
      p_lb   = e_disp;
      p_idx  = 16'(m_idx);
      p_lbd  = mem_rd(16'(m_base + m_idx));
      p_rv   = e_cpu && !cpu_we;
      p_rd   = mem_rd(cpu_addr);
      if (frame_start) m_ovr = 1'b0;
      if (line_start && m_left > 0) m_ovr = 1'b1;
      if (m_left > 0) begin
        m_fcyc++;
        if (e_disp) begin
          m_idx++;
          m_left--;
        end
      end else if (line_start && 32'(line_y) < LINES) begin
        m_base = (32'(line_y) * WPL) % 65536;
        m_idx  = 0;
        m_left = WPL;
        m_fcyc = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line(input logic [15:0] y);
    tick(); line_start = 1'b1; line_y = y;
    tick(); line_start = 1'b0;
  endtask

  int n_iss, first_i, last_i, n_lb, n_lbok, last_lb, done_i, g, n_cpu, n_disp, cpu_at_last;
  int unsigned d0;

  initial begin
    rst_n = 1'b0; line_start = 1'b1; frame_start = 1'b0; line_y = 16'd2;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0055; cpu_wdata = 32'hdead_beef;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; line_start = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0;
    repeat (3) tick();

    // Line 2 fetch: 80 consecutive reads, line buffer and done timing.
    pulse_line(16'd2);
    n_iss = 0; first_i = -1; last_i = -1; n_lb = 0; n_lbok = 0; last_lb = -1; done_i = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_en) begin
        n_iss++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      if (lb_we) begin
        if (lb_addr == 16'(n_lb) && lb_wdata == 32'(160 + n_lb)) n_lbok++;
        n_lb++;
        last_lb = i;
      end
      if (fetch_done) done_i = i;
    end
    check("l2_issues", 32'(n_iss), 32'd80);
    check("l2_first", 32'(first_i), 32'd0);
    check("l2_last", 32'(last_i), 32'd79);
    check("l2_lb_ok", 32'(n_lbok), 32'd80);
    check("l2_last_lb", 32'(last_lb), 32'd80);
    check("l2_done", 32'(done_i), 32'd81);

    // Out-of-range line is ignored.
    pulse_line(16'd480);
    n_iss = 0; done_i = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_en) n_iss++;
      if (fetch_done) done_i++;
    end
    check("l480_issues", 32'(n_iss), 32'd0);
    check("l480_done", 32'(done_i), 32'd0);

    // CPU read held across a fetch.
    pulse_line(16'd3);
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    g = -1;
    for (int i = 0; i < 120 && g < 0; i++) begin
      @(negedge clk);
      if (cpu_ready) g = i;
    end
    check("cpu_wait", 32'(g), SLOT_EN ? 32'd3 : 32'd80);
    tick(); cpu_valid = 1'b0;
    @(negedge clk);
    check("cpu_rvalid_dir", 32'(cpu_rvalid), 32'd1);
    check("cpu_rdata_dir", cpu_rdata, 32'h0000_1234);
    repeat (100) tick();

`ifdef VGA_FB_CPU_SLOT_EN
    // CPU held continuously: line completes in 107 cycles with 27 CPU grants.
    tick(); line_start = 1'b1; line_y = 16'd2; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    n_cpu = 0; n_disp = 0; last_i = -1; cpu_at_last = -1;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (cpu_ready) n_cpu++;
      if (mem_en && !cpu_ready) begin
        n_disp++;
        last_i = i;
        cpu_at_last = n_cpu;
      end
      tick(); line_start = 1'b0;
    end
    cpu_valid = 1'b0;
    check("slot_disp", 32'(n_disp), 32'd80);
    check("slot_len", 32'(last_i), 32'd106);
    check("slot_cpu", 32'(cpu_at_last), 32'd27);
    repeat (5) tick();
`endif

    // Second line_start mid-fetch sets overrun; first fetch completes.
    d0 = disp_cnt;
    pulse_line(16'd5);
    repeat (9) tick();
    line_start = 1'b1; line_y = 16'd6;
    tick(); line_start = 1'b0;
    @(negedge clk);
    check("ovr_set", 32'(overrun), 32'd1);
    repeat (100) tick();
    check("ovr_fetch_len", disp_cnt - d0, 32'd80);
    check("ovr_fetch_last", 32'(last_disp_addr), 32'd479);
    tick(); frame_start = 1'b1;
    tick(); frame_start = 1'b0;
    @(negedge clk);
    check("ovr_clear", 32'(overrun), 32'd0);

    // Asynchronous reset at word 40, then restart from word 0.
    pulse_line(16'd7);
    repeat (5) tick();
    line_start = 1'b1; line_y = 16'd0;
    tick(); line_start = 1'b0;
    repeat (34) tick();
    check("w40_addr", 32'(mem_addr), 32'd600);
    check("w40_ovr", 32'(overrun), 32'd1);
    #1; rst_n = 1'b0; cpu_valid = 1'b1;
    #1;
    check("async_flags", 32'({cpu_ready, cpu_rvalid, mem_en, mem_we, lb_we, fetch_done, overrun}), 32'h0);
    check("async_addr", {mem_addr, lb_addr}, 32'h0);
    check("async_data", mem_wdata | lb_wdata | cpu_rdata, 32'h0);
    tick(); tick();
    rst_n = 1'b1; cpu_valid = 1'b0; line_start = 1'b1; line_y = 16'd1;
    tick(); line_start = 1'b0;
    @(negedge clk);
    check("restart_addr", 32'(mem_addr), 32'd80);
    tick();
    @(negedge clk);
    check("restart_lb", 32'({lb_we, lb_addr}), 32'h0001_0000);
    repeat (100) tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      line_start  = ($urandom_range(0, 59) == 0);
      line_y      = 16'($urandom_range(0, 520));
      frame_start = ($urandom_range(0, 79) == 0);
      if (!cpu_valid || acc_q) begin
        cpu_valid = ($urandom_range(0, 2) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(0, 1023));
        cpu_wdata = $urandom;
      end
    end
    tick(); line_start = 1'b0; frame_start = 1'b0; cpu_valid = 1'b0;
    repeat (200) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 80, meaning framebuffer words fetched per scanline.
REQ-002 SHALL have parameter LINES, default 480, meaning visible lines; lines at or above this index are not fetched.
REQ-003 SHALL have parameter ADDR_W, default 16, meaning framebuffer word-address width.
REQ-004 SHALL have parameter DATA_W, default 32, meaning framebuffer word width.
REQ-005 SHALL have one clock and one reset: clk is the single clock, and rst_n is an asynchronous, active-low reset.
REQ-006 SHALL have these ports, one per line:
- clk  in  1  25 MHz pixel clock
- rst_n  in  1  asynchronous active-low reset
- line_start  in  1  one-cycle pulse requesting prefetch of line line_y
- frame_start  in  1  one-cycle pulse at frame begin
- line_y  in  16  line to fetch, sampled with line_start
- cpu_valid  in  1  CPU request valid
- cpu_ready  out  1  CPU request accepted this cycle
- cpu_we  in  1  CPU write (1) or read (0)
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- mem_en  out  1  framebuffer access strobe
- mem_we  out  1  framebuffer write
- mem_addr  out  ADDR_W  framebuffer address
- mem_wdata  out  DATA_W  framebuffer write data
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_en with mem_we=0
- lb_we  out  1  line-buffer write strobe
- lb_addr  out  16  line-buffer word index
- lb_wdata  out  DATA_W  line-buffer data
- fetch_done  out  1  one-cycle pulse after the last line-buffer write of a line
- overrun  out  1  sticky flag: line_start arrived while a fetch was in progress

Function
REQ-007 SHALL implement a state machine with two states, IDLE and FETCH.
REQ-008 In IDLE, a line_start with line_y < LINES SHALL latch base = line_y*WORDS_PER_LINE (truncated to ADDR_W), clear the word counter, and enter FETCH next cycle.
REQ-009 In IDLE, a line_start with line_y >= LINES SHALL be ignored.
REQ-010 In FETCH, each display-granted cycle SHALL drive mem_en=1, mem_we=0, mem_addr=base+word, and increment word.
REQ-011 After the read with word=WORDS_PER_LINE-1 is issued, the block SHALL return to IDLE.
REQ-012 One cycle after each display read issue, the block SHALL assert lb_we=1 with lb_addr=word index and lb_wdata=mem_rdata.
REQ-013 fetch_done SHALL pulse one cycle after the final lb_we.
REQ-014 In IDLE, cpu_ready SHALL equal cpu_valid; on acceptance the block SHALL drive mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata in the same cycle.
REQ-015 cpu_ready SHALL be combinational; the CPU holds cpu_addr, cpu_we and cpu_wdata stable while cpu_valid=1 and cpu_ready=0.
REQ-016 An accepted CPU read SHALL produce cpu_rvalid=1 and cpu_rdata=mem_rdata exactly one cycle later; an accepted write SHALL produce no cpu_rvalid.
REQ-017 In FETCH, the display SHALL have strict priority, with cpu_ready=0 except as set by REQ-023.
REQ-018 A line_start arriving in FETCH SHALL be ignored and SHALL set overrun; the current fetch continues unchanged.
REQ-019 frame_start SHALL clear overrun; if frame_start and an overrun condition occur in the same cycle, set SHALL win.
REQ-020 If line_start and cpu_valid coincide in IDLE, the CPU SHALL be granted that cycle and FETCH SHALL begin next cycle.
REQ-021 mem_en SHALL be 0 whenever no grant exists; at most one access SHALL be issued per cycle.

Reset
REQ-022 Asserting rst_n=0 at any time, including mid-fetch, SHALL immediately force state=IDLE, word=0, base=0, and all outputs (mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata, cpu_ready, cpu_rvalid, cpu_rdata, fetch_done, overrun) to 0; the aborted fetch is not resumed.

Configuration
REQ-023 With macro VGA_FB_CPU_SLOT_EN defined, a free-running 2-bit slot counter in FETCH SHALL give the slot to the CPU every 4th cycle (count=3) when cpu_valid=1, with display issue paused that cycle; without the macro, FETCH SHALL be display-only and a fetch SHALL take exactly WORDS_PER_LINE issue cycles.

Verification
REQ-024 line_start with line_y=2 and mem_rdata=address -> reads at addresses 160..239 on 80 consecutive cycles, lb_wdata=160..239 at lb_addr 0..79, fetch_done one cycle after lb_addr=79.
REQ-025 line_start with line_y=480 -> no mem_en, no fetch_done.
REQ-026 cpu_valid read at addr 0x1234 held during FETCH (macro undefined) -> cpu_ready=0 until IDLE, then granted; cpu_rvalid one cycle later with the data.
REQ-027 With VGA_FB_CPU_SLOT_EN defined and cpu_valid held continuously -> CPU granted on every 4th FETCH cycle; the line completes in 107 cycles (80 display + 27 CPU); line-buffer contents are unchanged.
REQ-028 Second line_start 10 cycles into a fetch -> overrun=1 and the first fetch completes; frame_start -> overrun=0.
REQ-029 rst_n=0 at word 40 -> all outputs 0 asynchronously; after release, a new line_start restarts at word 0.
